// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller front-end.
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_PEND = 2'd1;
    localparam logic [1:0] ADDR_VEC  = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam int unsigned GIE_BIT   = 0;
    localparam int unsigned EOI_BIT   = 1;
    localparam int unsigned INSVC_BIT = 2;

endpackage

// File: rtl/interrupt_controller_if.sv
// Register bus between the interrupt handler (master) and the controller (slave).
interface interrupt_controller_if;
    logic        RegWE;
    logic [1:0]  RegAddr;
    logic [31:0] RegWData;
    logic [31:0] RegRData;

    modport master (output RegWE, output RegAddr, output RegWData, input  RegRData);
    modport slave  (input  RegWE, input  RegAddr, input  RegWData, output RegRData);
endinterface

// File: rtl/intc_edge_detect.sv
// Per-bit rising-edge detector; IRQ_SYNC_EN adds a two-flop synchronizer in front.
module intc_edge_detect #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);

`ifdef IRQ_SYNC_EN
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
`endif
    logic [WIDTH-1:0] samp_q, samp_d;
    logic [WIDTH-1:0] hist_q, hist_d;

    always_comb begin
`ifdef IRQ_SYNC_EN
        sync1_d = din;
        sync2_d = sync1_q;
        samp_d  = sync2_q;
`else
        samp_d  = din;
`endif
        hist_d  = samp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef IRQ_SYNC_EN
            sync1_q <= '0;
            sync2_q <= '0;
`endif
            samp_q  <= '0;
            hist_q  <= '0;
        end else begin
`ifdef IRQ_SYNC_EN
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
`endif
            samp_q  <= samp_d;
            hist_q  <= hist_d;
        end
    end

    assign rise = samp_q & ~hist_q;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt front-end for the multi-cycle MIPS controller: edge-latched IRQ/NMI,
// mask/pend/vec/ctrl registers, INT/NMI/INTD drive. Optional macro: IRQ_SYNC_EN.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 4,
    parameter int unsigned VEC_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [NUM_IRQ-1:0]     Irq,
    input  logic                   NmiPin,
    input  logic                   isInterrupted,
    input  logic                   INA,
    interrupt_controller_if.slave  bus,
    output logic                   INT,
    output logic                   NMI,
    output logic                   INTD,
    output logic [VEC_W-1:0]       Vector
);

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic               gie_q, gie_d;
    logic               nmi_q, nmi_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               isint_q, isint_d;

    logic [NUM_IRQ-1:0] irq_rise;
    logic               nmi_rise;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] pend_clr;
    logic [VEC_W-1:0]   sel;
    logic               req, ack, eoi;
    logic               wr_mask, wr_pend, wr_ctrl;
    logic [31:0]        rdata;
    logic               unused_wdata;

    intc_edge_detect #(.WIDTH(NUM_IRQ)) u_irq_edge (
        .clk   (Clk),
        .rst_n (Rst_n),
        .din   (Irq),
        .rise  (irq_rise)
    );

    intc_edge_detect #(.WIDTH(1)) u_nmi_edge (
        .clk   (Clk),
        .rst_n (Rst_n),
        .din   (NmiPin),
        .rise  (nmi_rise)
    );

    assign unused_wdata = ^bus.RegWData;

    // Request, acknowledge and priority selection.
    always_comb begin
        wr_mask = bus.RegWE && (bus.RegAddr == ADDR_MASK);
        wr_pend = bus.RegWE && (bus.RegAddr == ADDR_PEND);
        wr_ctrl = bus.RegWE && (bus.RegAddr == ADDR_CTRL);
        eoi     = wr_ctrl && bus.RegWData[EOI_BIT];
        ack     = isInterrupted && !isint_q;
        active  = pend_q & mask_q;
        req     = (|active) && gie_q;
        sel     = '0;
        for (int unsigned i = NUM_IRQ; i > 0; i--) begin
            if (active[i-1]) sel = VEC_W'(i - 1);
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        pend_clr = '0;
        unique case (state_q)
            IDLE: begin
                if (req) state_d = REQ;
            end
            REQ: begin
                if (ack && INA && req) begin
                    state_d  = SERVICE;
                    vec_d    = sel;
                    pend_clr = NUM_IRQ'(1) << sel;
                end else if (!req) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) state_d = req ? REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A fresh edge overrides any clear landing in the same cycle.
    always_comb begin
        mask_d  = wr_mask ? bus.RegWData[NUM_IRQ-1:0] : mask_q;
        gie_d   = wr_ctrl ? bus.RegWData[GIE_BIT] : gie_q;
        pend_d  = (pend_q & ~(pend_clr | (wr_pend ? bus.RegWData[NUM_IRQ-1:0] : '0))) | irq_rise;
        nmi_d   = (nmi_q & ~(ack && !INA)) | nmi_rise;
        isint_d = isInterrupted;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            pend_q  <= '0;
            gie_q   <= 1'b0;
            nmi_q   <= 1'b0;
            vec_q   <= '0;
            isint_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            gie_q   <= gie_d;
            nmi_q   <= nmi_d;
            vec_q   <= vec_d;
            isint_q <= isint_d;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (bus.RegAddr)
            ADDR_MASK: rdata[NUM_IRQ-1:0] = mask_q;
            ADDR_PEND: rdata[NUM_IRQ-1:0] = pend_q;
            ADDR_VEC:  rdata[VEC_W-1:0]   = vec_q;
            ADDR_CTRL: begin
                rdata[GIE_BIT]   = gie_q;
                rdata[INSVC_BIT] = (state_q == SERVICE);
            end
            default:   rdata = '0;
        endcase
    end

    assign bus.RegRData = rdata;
    assign INT    = (state_q == REQ);
    assign NMI    = nmi_q;
    assign INTD   = (state_q == SERVICE) || !gie_q;
    assign Vector = vec_q;

endmodule
